// File: rtl/riscv_rb_param.sv
// Parametrised register bank with NRD combinational read ports, one write
// port, optional write-to-read bypass and hardwired-zero r0. It also holds a
// per-register pending scoreboard and a sequenced clear engine that zeroes the
// bank one register per cycle.
module riscv_rb_param #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned NRD     = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rs_pending,
  input  logic                iss_vld,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy_vec,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            clr_busy_q;
  logic            clr_done_q;
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic            idle;
  logic            wr_legal;
  logic            iss_legal;
  logic            byp_en;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  assign idle      = (state_q == StIdle);
  // Writes and issues targeting a hardwired r0 are dropped entirely.
  assign wr_legal  = we && !(ZERO_R0 && (wa == '0));
  assign iss_legal = iss_vld && !(ZERO_R0 && (iss_rd == '0));
  // Forwarding is only meaningful when the write will actually land this edge.
  assign byp_en    = BYPASS && ce && idle && wr_legal;

  // Select the single array write: writeback in idle, zero-fill while sweeping.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = wd;
    if (ce) begin
      if (idle && wr_legal) begin
        wr_en = 1'b1;
      end else if (state_q == StSweep) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
      end
    end
  end

  // Register array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state; a same-index issue overrides the write's clear.
  always_comb begin
    busy_d = busy_q;
    if (ce) begin
      if (idle) begin
        if (wr_legal)  busy_d[wa]     = 1'b0;
        if (iss_legal) busy_d[iss_rd] = 1'b1;
      end else if (state_q == StSweep) begin
        busy_d[cnt_q] = 1'b0;
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Clear engine: IDLE -> SWEEP (one register per cycle) -> DONE pulse -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q    <= StSweep;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        StSweep: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(NREG - 1)) begin
            state_q    <= StDone;
            clr_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-port read mux and pending flag.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    logic          is_r0;
    logic          hit;
    assign ra_k  = ra[k*AW +: AW];
    assign is_r0 = ZERO_R0 && (ra_k == '0);
    assign hit   = byp_en && (wa == ra_k);
    assign rdata[k*XLEN +: XLEN] = is_r0 ? '0 : (hit ? wd : regs_q[ra_k]);
    assign rs_pending[k]         = !is_r0 && busy_q[ra_k] && !hit;
  end

  assign busy_vec = busy_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_riscv_rb_param.sv
// Bench for riscv_rb_param: two instances (bypass + zero-r0, and neither)
// share stimulus and are compared every cycle against a behavioural model.
module tb_riscv_rb_param;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst, ce, we, iss_vld, clr_req;
  logic [AW-1:0]       wa, iss_rd;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic [NRD-1:0]      pend_a, pend_b;
  logic [NREG-1:0]     busy_a, busy_b;
  logic                cbusy_a, cbusy_b, cdone_a, cdone_b;

  riscv_rb_param #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wa(wa), .wd(wd), .ra(ra), .rdata(rdata_a),
    .rs_pending(pend_a), .iss_vld(iss_vld), .iss_rd(iss_rd), .busy_vec(busy_a),
    .clr_req(clr_req), .clr_busy(cbusy_a), .clr_done(cdone_a)
  );

  riscv_rb_param #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wa(wa), .wd(wd), .ra(ra), .rdata(rdata_b),
    .rs_pending(pend_b), .iss_vld(iss_vld), .iss_rd(iss_rd), .busy_vec(busy_b),
    .clr_req(clr_req), .clr_busy(cbusy_b), .clr_done(cdone_b)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: instance 0 = bypass+zero-r0, instance 1 = plain.
  logic [XLEN-1:0] mregs [2][NREG];
  bit              mbusy [2][NREG];
  int              phase;  // -1 idle, 0..NREG-1 next register to clear, NREG done

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit legal(int d, logic [AW-1:0] a);
    return !(d == 0 && a == 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int d, logic [AW-1:0] a);
    if (d == 0 && a == 0) return '0;
    if (d == 0 && ce && phase < 0 && we && legal(d, wa) && wa == a) return wd;
    return mregs[d][a];
  endfunction

  function automatic logic exp_pend(int d, logic [AW-1:0] a);
    bit hit;
    if (d == 0 && a == 0) return 1'b0;
    hit = (d == 0) && ce && phase < 0 && we && wa == a;
    return mbusy[d][a] && !hit;
  endfunction

  function automatic logic [NREG-1:0] exp_busy(int d);
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = mbusy[d][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREG; i++) begin
        mregs[d][i] = '0;
        mbusy[d][i] = 1'b0;
      end
    phase = -1;
  endtask

  task automatic model_update();
    if (!ce) return;
    if (phase < 0) begin
      for (int d = 0; d < 2; d++) begin
        if (we && legal(d, wa)) begin
          mregs[d][wa] = wd;
          mbusy[d][wa] = 1'b0;
        end
        if (iss_vld && legal(d, iss_rd)) mbusy[d][iss_rd] = 1'b1;
      end
      if (clr_req) phase = 0;
    end else if (phase < NREG) begin
      for (int d = 0; d < 2; d++) begin
        mregs[d][phase] = '0;
        mbusy[d][phase] = 1'b0;
      end
      phase++;
    end else begin
      phase = -1;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rdata_a[%0d]", k), rdata_a[k*XLEN +: XLEN], exp_rd(0, ra[k*AW +: AW]));
      check($sformatf("rdata_b[%0d]", k), rdata_b[k*XLEN +: XLEN], exp_rd(1, ra[k*AW +: AW]));
      check($sformatf("pend_a[%0d]", k), pend_a[k], exp_pend(0, ra[k*AW +: AW]));
      check($sformatf("pend_b[%0d]", k), pend_b[k], exp_pend(1, ra[k*AW +: AW]));
    end
    check("busy_vec_a", busy_a, exp_busy(0));
    check("busy_vec_b", busy_b, exp_busy(1));
    check("clr_busy_a", cbusy_a, phase >= 0);
    check("clr_busy_b", cbusy_b, phase >= 0);
    check("clr_done_a", cdone_a, phase == NREG);
    check("clr_done_b", cdone_b, phase == NREG);
  endtask

  // Inputs are set at the falling edge; check, then take one rising edge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ce = 1'b1; we = 1'b0; iss_vld = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    int busy_cnt, done_cnt;
    rst = 1'b1; ce = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    iss_vld = 1'b0; iss_rd = '0; clr_req = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_busy_vec", busy_a, '0);
    check("reset_clr_busy", cbusy_a, 1'b0);
    cycle();
    rst = 1'b0;
    idle_inputs();

    // Write r5, read it back on both ports.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; cycle();
    we = 1'b0; set_ra(5'd5, 5'd5);
    #1;
    check("r5_port0", rdata_a[31:0], 32'hDEADBEEF);
    check("r5_port1", rdata_a[63:32], 32'hDEADBEEF);
    cycle();

    // r0 write: dropped when hardwired, stored otherwise.
    we = 1'b1; wa = 5'd0; wd = 32'h1234; cycle();
    we = 1'b0; set_ra(5'd0, 5'd0);
    #1;
    check("r0_zero", rdata_a[31:0], 32'h0);
    check("r0_plain", rdata_b[31:0], 32'h1234);
    cycle();

    // Same-cycle forwarding.
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; set_ra(5'd7, 5'd5);
    #1;
    check("bypass_hit", rdata_a[31:0], 32'hA5A5A5A5);
    check("no_bypass_old", rdata_b[31:0], 32'h0);
    cycle();
    we = 1'b0;

    // Scoreboard.
    iss_vld = 1'b1; iss_rd = 5'd3; cycle();
    iss_vld = 1'b0; set_ra(5'd3, 5'd4);
    #1;
    check("busy3_set", busy_a[3], 1'b1);
    check("pend3_set", pend_a[0], 1'b1);
    cycle();
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    #1;
    check("pend3_bypassed", pend_a[0], 1'b0);
    check("pend3_no_bypass", pend_b[0], 1'b1);
    cycle();
    we = 1'b0;
    #1;
    check("busy3_cleared", busy_a[3], 1'b0);
    cycle();
    iss_vld = 1'b1; iss_rd = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h44; cycle();
    iss_vld = 1'b1; iss_rd = 5'd4; we = 1'b1; wa = 5'd9; wd = 32'h99; cycle();
    iss_vld = 1'b0; we = 1'b0;
    #1;
    check("busy3_new_producer", busy_a[3], 1'b1);
    check("busy4_other_index", busy_a[4], 1'b1);
    cycle();

    // Fill and sweep; stray writes/issues/requests during the sweep are ignored.
    for (int i = 0; i < NREG; i++) begin
      we = 1'b1; wa = AW'(i); wd = $urandom | 32'h1; cycle();
    end
    we = 1'b0;
    clr_req = 1'b1; cycle();
    busy_cnt = 0; done_cnt = 0;
    for (int j = 0; j <= NREG + 2; j++) begin
      set_ra(AW'(j - 1), AW'(j));
      we = (j <= NREG) ? 1'($urandom) : 1'b0;
      wa = AW'(j);
      wd = $urandom;
      iss_vld = (j <= NREG) ? 1'($urandom) : 1'b0;
      iss_rd = AW'($urandom);
      clr_req = (j < NREG) ? 1'($urandom) : 1'b0;
      #1;
      if (j >= 1 && j <= NREG) check("swept_reads_zero", rdata_a[31:0], 32'h0);
      if (cbusy_a) busy_cnt++;
      if (cdone_a) done_cnt++;
      cycle();
    end
    idle_inputs();
    check("sweep_busy_cycles", busy_cnt, NREG + 1);
    check("sweep_done_pulses", done_cnt, 1);
    check("sweep_busy_vec", busy_a, '0);

    // Clock-enable freeze mid-sweep.
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; wa = AW'(i); wd = $urandom | 32'h1; cycle();
    end
    we = 1'b0; clr_req = 1'b1; cycle();
    clr_req = 1'b0; busy_cnt = 0;
    for (int j = 0; j < NREG + 6; j++) begin
      ce = !(j >= 5 && j < 8);
      set_ra(AW'($urandom), AW'(j));
      #1;
      if (cbusy_a) busy_cnt++;
      cycle();
    end
    ce = 1'b1;
    check("freeze_busy_cycles", busy_cnt, NREG + 4);

    // Asynchronous reset in the middle of a sweep.
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; wa = AW'(i); wd = $urandom | 32'h1; cycle();
    end
    we = 1'b0; clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    for (int j = 0; j < 10; j++) cycle();
    rst = 1'b1; set_ra(5'd20, 5'd31);
    model_reset();
    #1;
    check("rst_clr_busy", cbusy_a, 1'b0);
    check("rst_reg20", rdata_a[31:0], 32'h0);
    cycle();
    rst = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < NREG + 4; j++) begin
      #1;
      if (cdone_a) done_cnt++;
      cycle();
    end
    check("rst_no_done", done_cnt, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) model_reset();
      ce = ($urandom_range(0, 9) != 0);
      we = 1'($urandom);
      wa = AW'($urandom);
      wd = $urandom;
      iss_vld = ($urandom_range(0, 3) == 0);
      iss_rd = AW'($urandom);
      clr_req = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NRD; k++)
        ra[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
